// File: rtl/nec_ir_receiver.sv
// NEC infrared frame decoder: measures mark/space widths in microseconds and
// publishes validated frames, a one-cycle command strobe, and repeat/error pulses.
module nec_ir_receiver #(
  parameter int unsigned TICK_DIV   = 50,
  parameter int unsigned TIMEOUT_US = 12000,
  parameter bit          CHECK_ADDR = 1'b1
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        IRDA_RXD,
  output logic [31:0] hex_data,
  output logic [7:0]  IR_button,
  output logic        data_ready,
  output logic        repeat_pulse,
  output logic        frame_error
);

  localparam int unsigned WW = 14;
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] P_LAST    = PW'(TICK_DIV - 1);
  localparam logic [WW-1:0] W_MAX     = '1;
  localparam logic [WW-1:0] TIMEOUT_W = WW'(TIMEOUT_US);

  localparam logic [WW-1:0] BURST_LO = WW'(300);
  localparam logic [WW-1:0] BURST_HI = WW'(800);
  localparam logic [WW-1:0] LEAD_LO  = WW'(8000);
  localparam logic [WW-1:0] LEAD_HI  = WW'(10000);
  localparam logic [WW-1:0] SPACE_LO = WW'(3500);
  localparam logic [WW-1:0] SPACE_HI = WW'(5500);
  localparam logic [WW-1:0] REP_LO   = WW'(1750);
  localparam logic [WW-1:0] REP_HI   = WW'(2750);
  localparam logic [WW-1:0] ZERO_LO  = WW'(300);
  localparam logic [WW-1:0] ZERO_HI  = WW'(800);
  localparam logic [WW-1:0] ONE_LO   = WW'(1400);
  localparam logic [WW-1:0] ONE_HI   = WW'(2000);

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD_LOW, S_LEAD_HIGH, S_BIT_LOW, S_BIT_HIGH, S_STOP_LOW, S_REP_END
  } state_t;

  state_t        state;
  logic [1:0]    sync_q;
  logic          level_q;
  logic [PW-1:0] pre_q;
  logic          tick_q;
  logic [WW-1:0] width_q;
  logic [4:0]    bit_cnt_q;
  logic [31:0]   shift_q;
  logic          check_q;
  logic          rep_q;
  logic          seen_q;

  logic rise_c, fall_c, edge_c;
  logic burst_c, zero_c, one_c, frame_ok_c;

  function automatic logic in_win(input logic [WW-1:0] w,
                                  input logic [WW-1:0] lo,
                                  input logic [WW-1:0] hi);
    return (w >= lo) && (w <= hi);
  endfunction

  assign rise_c  = sync_q[1] & ~level_q;
  assign fall_c  = ~sync_q[1] & level_q;
  assign edge_c  = rise_c | fall_c;
  assign burst_c = in_win(width_q, BURST_LO, BURST_HI);
  assign zero_c  = in_win(width_q, ZERO_LO, ZERO_HI);
  assign one_c   = in_win(width_q, ONE_LO, ONE_HI);
  assign frame_ok_c = (shift_q[23:16] == ~shift_q[31:24]) &&
                      ((CHECK_ADDR == 1'b0) || (shift_q[7:0] == ~shift_q[15:8]));

  // Synchronizer and edge register idle high so reset never fakes an edge.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
    end else begin
      sync_q  <= {sync_q[0], IRDA_RXD};
      level_q <= sync_q[1];
    end
  end

  // 1 us tick prescaler and saturating level-width counter.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      pre_q   <= '0;
      tick_q  <= 1'b0;
      width_q <= '0;
    end else begin
      if (pre_q == P_LAST) begin
        pre_q  <= '0;
        tick_q <= 1'b1;
      end else begin
        pre_q  <= pre_q + PW'(1);
        tick_q <= 1'b0;
      end
      if (edge_c) width_q <= '0;
      else if (tick_q && (width_q != W_MAX)) width_q <= width_q + WW'(1);
    end
  end

  // Frame FSM; any out-of-window level aborts to idle.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      check_q   <= 1'b0;
      rep_q     <= 1'b0;
    end else begin
      check_q <= 1'b0;
      rep_q   <= 1'b0;
      if ((state != S_IDLE) && !edge_c && (width_q >= TIMEOUT_W)) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (fall_c) state <= S_LEAD_LOW;
          S_LEAD_LOW:
            if (edge_c)
              state <= (rise_c && in_win(width_q, LEAD_LO, LEAD_HI)) ? S_LEAD_HIGH : S_IDLE;
          S_LEAD_HIGH:
            if (edge_c) begin
              if (fall_c && in_win(width_q, SPACE_LO, SPACE_HI)) begin
                state     <= S_BIT_LOW;
                bit_cnt_q <= '0;
              end else if (fall_c && in_win(width_q, REP_LO, REP_HI)) begin
                state <= S_REP_END;
              end else begin
                state <= S_IDLE;
              end
            end
          S_BIT_LOW:
            if (edge_c) state <= (rise_c && burst_c) ? S_BIT_HIGH : S_IDLE;
          S_BIT_HIGH:
            if (edge_c) begin
              if (fall_c && (zero_c || one_c)) begin
                shift_q   <= {one_c, shift_q[31:1]};
                bit_cnt_q <= bit_cnt_q + 5'd1;
                state     <= (bit_cnt_q == 5'd31) ? S_STOP_LOW : S_BIT_LOW;
              end else begin
                state <= S_IDLE;
              end
            end
          S_STOP_LOW:
            if (edge_c) begin
              check_q <= rise_c && burst_c;
              state   <= S_IDLE;
            end
          S_REP_END:
            if (edge_c) begin
              rep_q <= rise_c && burst_c;
              state <= S_IDLE;
            end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Output stage: validation result lands one clock after the stop burst.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      hex_data     <= '0;
      IR_button    <= '0;
      data_ready   <= 1'b0;
      repeat_pulse <= 1'b0;
      frame_error  <= 1'b0;
      seen_q       <= 1'b0;
    end else begin
      IR_button    <= '0;
      data_ready   <= 1'b0;
      repeat_pulse <= 1'b0;
      frame_error  <= 1'b0;
      if (check_q) begin
        if (frame_ok_c) begin
          hex_data   <= shift_q;
          IR_button  <= shift_q[23:16];
          data_ready <= 1'b1;
          seen_q     <= 1'b1;
        end else begin
          frame_error <= 1'b1;
        end
      end
      if (rep_q && seen_q) repeat_pulse <= 1'b1;
    end
  end

endmodule
